// File: rtl/udc_sequencer_if.sv
// Board-side bundle of the up/down counter sequencer: raw buttons and count
// readback in, counter controls and mode glyph out.
interface udc_sequencer_if;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_dir;
  logic [3:0] count_in;
  logic       cnt_en;
  logic       cnt_up;
  logic       cnt_clr;
  logic       busy;
  logic [6:0] seg;

  modport master (
    input  btn_start, btn_stop, btn_dir, count_in,
    output cnt_en, cnt_up, cnt_clr, busy, seg
  );

  modport slave (
    output btn_start, btn_stop, btn_dir, count_in,
    input  cnt_en, cnt_up, cnt_clr, busy, seg
  );
endinterface

// File: rtl/udc_sequencer.sv
// Run/pause/direction sequencer for a 4-bit up/down counter: button
// conditioning, clear/run/pause FSM, step prescaler and mode glyph.
module udc_sequencer #(
  parameter int TICK_DIV   = 4,
  parameter int DEB_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  udc_sequencer_if.master bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);

  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_U    = 7'b0111110;
  localparam logic [6:0] SEG_D    = 7'b1011110;
  localparam logic [6:0] SEG_P    = 7'b1110011;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, PAUSE} state_t;

  logic [2:0]    btn_raw;
  logic [2:0]    sync_p0;
  logic [2:0]    sync_p1;
  logic [2:0]    deb_lvl;
  logic [2:0]    deb_lvl_d;
  logic [2:0]    press;
  logic [DW-1:0] deb_cnt [3];

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic          dir;
  logic          dir_nxt;
  logic          dir_pend;
  logic          pend_nxt;
  logic          cnt_en_q;
  logic          en_nxt;
  logic          start_p;
  logic          stop_p;
  logic          dir_p;
  logic          tick;
  logic          at_limit;
  logic          dir_tgl;

  assign btn_raw = {bus.btn_dir, bus.btn_stop, bus.btn_start};

  // Button conditioning: 2-flop sync, debounce, registered rising-edge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      deb_lvl   <= '0;
      deb_lvl_d <= '0;
      press     <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync_p0   <= btn_raw;
      sync_p1   <= sync_p0;
      deb_lvl_d <= deb_lvl;
      press     <= deb_lvl & ~deb_lvl_d;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] != deb_lvl[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            deb_lvl[i] <= sync_p1[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign start_p = press[0];
  assign stop_p  = press[1];
  assign dir_p   = press[2];

  // Mode sequencing; stop outranks start when both arrive together
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_p && !stop_p) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN:     if (stop_p) state_nxt = PAUSE;
      PAUSE: begin
        if (stop_p)       state_nxt = IDLE;
        else if (start_p) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A tick on the way out of RUN is dropped entirely
  assign tick     = (state == RUN) && (presc == PRESC_MAX) && (state_nxt == RUN);
  assign at_limit = dir ? (bus.count_in == 4'hF) : (bus.count_in == 4'h0);
  assign dir_tgl  = dir_p && ((state == RUN) || (state == PAUSE));

  // A dir press landing on a stepping tick is deferred one cycle so the
  // strobe leaves with the old direction; on a bounce tick it is discarded.
  always_comb begin
    dir_nxt  = dir ^ dir_pend;
    pend_nxt = 1'b0;
    en_nxt   = 1'b0;
    if (state == IDLE && state_nxt == CLEAR) begin
      dir_nxt = 1'b1;
    end else if (tick && at_limit) begin
      dir_nxt = ~dir;
    end else if (tick) begin
      en_nxt   = 1'b1;
      pend_nxt = dir_tgl;
    end else if (dir_tgl) begin
      dir_nxt = ~(dir ^ dir_pend);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      dir      <= 1'b1;
      dir_pend <= 1'b0;
      cnt_en_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      dir_pend <= pend_nxt;
      cnt_en_q <= en_nxt;
      if (state != RUN && state_nxt == RUN) begin
        presc <= '0;
      end else if (state == RUN) begin
        presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
      end
    end
  end

  assign bus.cnt_en  = cnt_en_q;
  assign bus.cnt_up  = dir;
  assign bus.cnt_clr = (state == CLEAR);
  assign bus.busy    = (state == RUN) || (state == PAUSE);

  always_comb begin
    bus.seg = SEG_DASH;
    unique case (state)
      IDLE:    bus.seg = SEG_DASH;
      CLEAR:   bus.seg = SEG_U;
      RUN:     bus.seg = dir ? SEG_U : SEG_D;
      PAUSE:   bus.seg = SEG_P;
      default: bus.seg = SEG_DASH;
    endcase
  end

endmodule

// File: tb/tb_udc_sequencer.sv
// Bench for udc_sequencer: drives buttons, plays the role of the 4-bit counter,
// and compares every cycle against an event-scheduled model of the controller.
module tb_udc_sequencer;

  localparam int TD  = 4;
  localparam int DEB = 2;
  localparam int LAT = 4 + DEB;  // edges from a press being driven to the FSM reacting

  localparam int S_IDLE  = 0;
  localparam int S_CLEAR = 1;
  localparam int S_RUN   = 2;
  localparam int S_PAUSE = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  udc_sequencer_if bus ();

  udc_sequencer #(.TICK_DIV(TD), .DEB_CYCLES(DEB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int n      = 0;

  int   m_state;
  bit   m_dir;
  bit   m_en;
  int   m_cnt;
  int   run_entry;
  logic [2:0] ev   [64];
  bit         flip [64];

  logic       obs_en, obs_up, obs_clr;
  logic [3:0] plant;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic logic [6:0] exp_seg();
    case (m_state)
      S_CLEAR: return 7'b0111110;
      S_RUN:   return m_dir ? 7'b0111110 : 7'b1011110;
      S_PAUSE: return 7'b1110011;
      default: return 7'b1000000;
    endcase
  endfunction

  // Controller behaviour at one clock edge, with ticks taken from elapsed run time
  task automatic model_edge();
    int c_new, nxt;
    bit st, sp, dp, tk, dtg, fl, nd, ne;
    logic [2:0] e;
    c_new = m_cnt;
    if (m_state == S_CLEAR) c_new = 0;
    else if (m_en)          c_new = (m_cnt + (m_dir ? 1 : 15)) % 16;
    e  = ev[n % 64];   ev[n % 64]   = '0;
    fl = flip[n % 64]; flip[n % 64] = 1'b0;
    if (reset) begin
      m_state = S_IDLE; m_dir = 1'b1; m_en = 1'b0; m_cnt = c_new;
      for (int i = 0; i < 64; i++) begin ev[i] = '0; flip[i] = 1'b0; end
      return;
    end
    st = e[0]; sp = e[1]; dp = e[2];
    tk = (m_state == S_RUN) && (n > run_entry) && ((n - run_entry) % TD == 0);
    nxt = m_state;
    case (m_state)
      S_IDLE:  if (st && !sp) nxt = S_CLEAR;
      S_CLEAR: nxt = S_RUN;
      S_RUN:   if (sp) nxt = S_PAUSE;
      default: if (sp) nxt = S_IDLE; else if (st) nxt = S_RUN;
    endcase
    dtg = dp && (m_state == S_RUN || m_state == S_PAUSE);
    nd  = m_dir ^ fl;
    ne  = 1'b0;
    if (m_state == S_IDLE && nxt == S_CLEAR) nd = 1'b1;
    else if (tk && nxt == S_RUN) begin
      if ((m_dir && m_cnt == 15) || (!m_dir && m_cnt == 0)) nd = !m_dir;
      else begin
        ne = 1'b1;
        if (dtg) flip[(n + 1) % 64] = 1'b1;
      end
    end else if (dtg) nd = !nd;
    if (nxt == S_RUN && m_state != S_RUN) run_entry = n;
    m_state = nxt; m_dir = nd; m_en = ne; m_cnt = c_new;
  endtask

  task automatic cyc();
    @(posedge clk);
    n++;
    if (obs_clr === 1'b1)     plant = 4'd0;
    else if (obs_en === 1'b1) plant = (obs_up === 1'b1) ? plant + 4'd1 : plant - 4'd1;
    model_edge();
    #1 bus.count_in = plant;
    @(negedge clk);
    obs_en  = bus.cnt_en;
    obs_up  = bus.cnt_up;
    obs_clr = bus.cnt_clr;
    chk("cnt_en",  8'(bus.cnt_en),   8'(m_en));
    chk("cnt_up",  8'(bus.cnt_up),   8'(m_dir));
    chk("cnt_clr", 8'(bus.cnt_clr),  8'(m_state == S_CLEAR));
    chk("busy",    8'(bus.busy),     8'(m_state == S_RUN || m_state == S_PAUSE));
    chk("seg",     8'(bus.seg),      8'(exp_seg()));
    chk("count",   8'(bus.count_in), 8'(m_cnt));
  endtask

  task automatic cycles(input int k);
    repeat (k) cyc();
  endtask

  task automatic wait_edge(input int t);
    while (n < t) cyc();
  endtask

  // mask bits: 0 start, 1 stop, 2 dir
  task automatic press(input logic [2:0] mask, input int hold, input int gap);
    ev[(n + LAT) % 64] = ev[(n + LAT) % 64] | mask;
    bus.btn_start = mask[0];
    bus.btn_stop  = mask[1];
    bus.btn_dir   = mask[2];
    cycles(hold);
    bus.btn_start = 1'b0;
    bus.btn_stop  = 1'b0;
    bus.btn_dir   = 1'b0;
    cycles(gap);
  endtask

  task automatic glitch_dir();
    bus.btn_dir = 1'b1; cyc();
    bus.btn_dir = 1'b0; cyc();
    bus.btn_dir = 1'b1; cyc();
    bus.btn_dir = 1'b0; cycles(6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, t, op;
    int held;
    reset         = 1'b1;
    bus.btn_start = 1'b0;
    bus.btn_stop  = 1'b0;
    bus.btn_dir   = 1'b0;
    plant         = 4'($urandom_range(0, 15));
    bus.count_in  = plant;
    obs_en = 1'b0; obs_up = 1'b0; obs_clr = 1'b0;
    m_state = S_IDLE; m_dir = 1'b1; m_en = 1'b0; m_cnt = int'(plant); run_entry = 0;
    for (int i = 0; i < 64; i++) begin ev[i] = '0; flip[i] = 1'b0; end

    cycles(3);
    reset = 1'b0;
    cycles(3);
    chk("rst_seg",  8'(bus.seg),     8'h40);
    chk("rst_busy", 8'(bus.busy),    8'h00);
    chk("rst_up",   8'(bus.cnt_up),  8'h01);
    chk("rst_en",   8'(bus.cnt_en),  8'h00);
    chk("rst_clr",  8'(bus.cnt_clr), 8'h00);

    // Start, count up, bounce at 15, down to 0, bounce back up
    press(3'b001, DEB + 1, 6);
    e0 = run_entry;
    wait_edge(e0 + 2 * TD + 1);
    chk("run_cnt2", 8'(bus.count_in), 8'd2);
    chk("run_seg",  8'(bus.seg),      8'h3E);
    chk("run_busy", 8'(bus.busy),     8'h01);
    wait_edge(e0 + 16 * TD);
    chk("top_cnt",  8'(bus.count_in), 8'd15);
    chk("top_seg",  8'(bus.seg),      8'h5E);
    chk("top_up",   8'(bus.cnt_up),   8'h00);
    chk("top_en",   8'(bus.cnt_en),   8'h00);
    wait_edge(e0 + 17 * TD + 1);
    chk("down_cnt", 8'(bus.count_in), 8'd14);
    wait_edge(e0 + 32 * TD);
    chk("bot_cnt",  8'(bus.count_in), 8'd0);
    chk("bot_up",   8'(bus.cnt_up),   8'h01);
    chk("bot_en",   8'(bus.cnt_en),   8'h00);

    // Pause holds the count, resume continues without clear, stop twice idles
    cycles($urandom_range(5, 40));
    press(3'b010, DEB + 1, 6);
    held = m_cnt;
    cycles(20);
    chk("pause_cnt",  8'(bus.count_in), 8'(held));
    chk("pause_seg",  8'(bus.seg),      8'h73);
    chk("pause_busy", 8'(bus.busy),     8'h01);
    press(3'b001, DEB + 1, 30);
    press(3'b010, DEB + 1, 6);
    press(3'b010, DEB + 1, 6);
    chk("idle_seg",  8'(bus.seg),  8'h40);
    chk("idle_busy", 8'(bus.busy), 8'h00);

    // Glitches on dir, a real dir press, then start+stop together from RUN
    press(3'b001, DEB + 1, $urandom_range(6, 20));
    glitch_dir();
    press(3'b100, DEB + 1, $urandom_range(6, 20));
    press(3'b011, DEB + 1, 6);
    chk("both_seg", 8'(bus.seg), 8'h73);
    press(3'b010, DEB + 1, 6);

    // Dir press landing on the tick that sees count 5
    press(3'b001, DEB + 1, 6);
    t = run_entry + 6 * TD;
    wait_edge(t - LAT);
    press(3'b100, DEB + 1, 6);
    wait_edge(t + 1);
    chk("align_cnt6", 8'(bus.count_in), 8'd6);
    chk("align_down", 8'(bus.cnt_up),   8'h00);
    wait_edge(t + TD + 1);
    chk("align_cnt5", 8'(bus.count_in), 8'd5);

    // Reset arriving on a stepping tick
    for (int i = 0; i < TD + 2; i++) begin
      if ((n + 1 - run_entry) % TD == 0) break;
      cyc();
    end
    reset = 1'b1;
    cyc();
    chk("rr_en",   8'(bus.cnt_en),  8'h00);
    chk("rr_seg",  8'(bus.seg),     8'h40);
    chk("rr_busy", 8'(bus.busy),    8'h00);
    chk("rr_up",   8'(bus.cnt_up),  8'h01);
    chk("rr_clr",  8'(bus.cnt_clr), 8'h00);
    reset = 1'b0;
    cycles(3);

    // Random button activity
    for (int k = 0; k < 14; k++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: press(3'b001, $urandom_range(DEB + 1, DEB + 4), $urandom_range(6, 40));
        1: press(3'b010, $urandom_range(DEB + 1, DEB + 4), $urandom_range(6, 40));
        2: press(3'b100, $urandom_range(DEB + 1, DEB + 4), $urandom_range(6, 40));
        3: press(3'b011, $urandom_range(DEB + 1, DEB + 4), $urandom_range(6, 40));
        default: glitch_dir();
      endcase
    end
    cycles(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
